// File: rtl/inert_serf.sv
// SPI serf standing in for the 6-axis inertial sensor: 16-bit frames, register map, Z-gyro sampler and INT.
// Optional block-data-update on OUTZ_L/OUTZ_H is enabled by defining INERT_SERF_BDU_EN.
module inert_serf #(
  parameter int          SMPL_CYCLES  = 1024,
  parameter logic [7:0]  WHO_AM_I_VAL = 8'h6A
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               SS_n,
  input  logic               SCLK,
  input  logic               MOSI,
  output logic               MISO,
  output logic               INT,
  input  logic signed [15:0] yaw_in,
  output logic               smpl,
  output logic               gyro_en
);

  localparam int CW = $clog2(SMPL_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [2:0]    r_ss_sync, r_sclk_sync, r_mosi_sync;
  logic [4:0]    r_bit_cnt;
  logic [15:0]   r_shft;
  logic [7:0]    r_cmd;
  logic          r_miso;
  logic [7:0]    r_int1, r_ctrl2, r_ctrl5;
  logic [15:0]   r_outz;
  logic          r_int, r_smpl;
  logic [CW-1:0] r_smpl_cnt;

  logic       w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall, w_mosi;
  logic [7:0] w_cmd_nxt, w_rd_val;
  logic       w_done, w_wr_commit, w_rd26_done, w_rd27_done, w_wrap;
  logic       w_load_yaw, w_load_pend, w_int_set, w_int_clr_wr;
  logic [15:0] w_pend;

  assign w_ss_fall   =  r_ss_sync[2] & ~r_ss_sync[1];
  assign w_ss_rise   = ~r_ss_sync[2] &  r_ss_sync[1];
  assign w_sclk_rise = ~r_sclk_sync[2] &  r_sclk_sync[1];
  assign w_sclk_fall =  r_sclk_sync[2] & ~r_sclk_sync[1];
  assign w_mosi      = r_mosi_sync[2];
  assign w_cmd_nxt   = {r_shft[6:0], w_mosi};

  assign w_done       = (r_state == S_DONE) && w_ss_rise;
  assign w_wr_commit  = w_done && !r_cmd[7];
  assign w_rd26_done  = w_done && r_cmd[7] && (r_cmd[6:0] == 7'h26);
  assign w_rd27_done  = w_done && r_cmd[7] && (r_cmd[6:0] == 7'h27);
  assign w_int_clr_wr = w_wr_commit && (r_cmd[6:0] == 7'h0D) && !r_shft[1];
  assign w_wrap       = gyro_en && (r_smpl_cnt == CW'(SMPL_CYCLES - 1));

  assign MISO    = r_miso;
  assign INT     = r_int;
  assign smpl    = r_smpl;
  assign gyro_en = |r_ctrl2;

  // Sync flops reload from the pins on reset so a frame already in flight is not mistaken for a new SS_n fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ss_sync   <= {3{SS_n}};
      r_sclk_sync <= {3{SCLK}};
      r_mosi_sync <= '0;
    end else begin
      r_ss_sync   <= {r_ss_sync[1:0], SS_n};
      r_sclk_sync <= {r_sclk_sync[1:0], SCLK};
      r_mosi_sync <= {r_mosi_sync[1:0], MOSI};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_ss_fall) w_state_nxt = S_CMD;
      S_CMD: begin
        if (w_ss_rise) w_state_nxt = S_IDLE;
        else if (w_sclk_rise && r_bit_cnt == 5'd7) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_ss_rise) w_state_nxt = S_IDLE;
        else if (w_sclk_rise && r_bit_cnt == 5'd15) w_state_nxt = S_DONE;
      end
      S_DONE: if (w_ss_rise) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_val = 8'h00;
    case (w_cmd_nxt[6:0])
      7'h0D:   w_rd_val = r_int1;
      7'h0F:   w_rd_val = WHO_AM_I_VAL;
      7'h11:   w_rd_val = r_ctrl2;
      7'h14:   w_rd_val = r_ctrl5;
      7'h26:   w_rd_val = r_outz[7:0];
      7'h27:   w_rd_val = r_outz[15:8];
      default: w_rd_val = 8'h00;
    endcase
  end

  // On the 8th rise the command byte is latched and the read value is staged so it leads on the next fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_shft    <= '0;
      r_cmd     <= '0;
      r_miso    <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_ss_fall) begin
        r_bit_cnt <= '0;
        r_shft    <= '0;
      end else if (r_state == S_CMD && w_sclk_rise) begin
        r_bit_cnt <= r_bit_cnt + 5'd1;
        if (r_bit_cnt == 5'd7) begin
          r_cmd  <= w_cmd_nxt;
          r_shft <= {(w_cmd_nxt[7] ? w_rd_val : 8'h00), 8'h00};
        end else begin
          r_shft <= {r_shft[14:0], w_mosi};
        end
      end else if (r_state == S_DATA && w_sclk_rise) begin
        r_bit_cnt <= r_bit_cnt + 5'd1;
        r_shft    <= {r_shft[14:0], w_mosi};
      end
      if (r_state != S_DATA || w_ss_rise) r_miso <= 1'b0;
      else if (w_sclk_fall)               r_miso <= r_shft[15];
    end
  end

`ifdef INERT_SERF_BDU_EN
  logic        r_freeze, r_pend_v;
  logic [15:0] r_pend;

  assign w_pend      = r_pend;
  assign w_load_yaw  = w_wrap && (!r_freeze || w_rd27_done);
  assign w_load_pend = r_freeze && w_rd27_done && r_pend_v && !w_wrap;
  assign w_int_set   = r_int1[1] && (w_load_yaw || (r_freeze && w_rd27_done && r_pend_v));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_freeze <= 1'b0;
      r_pend_v <= 1'b0;
      r_pend   <= '0;
    end else begin
      if (w_rd27_done)      r_freeze <= 1'b0;
      else if (w_rd26_done) r_freeze <= 1'b1;
      if (w_rd27_done) r_pend_v <= 1'b0;
      else if (w_wrap && r_freeze) begin
        r_pend_v <= 1'b1;
        r_pend   <= yaw_in;
      end
    end
  end
`else
  logic w_unused_rd26;
  assign w_unused_rd26 = w_rd26_done;
  assign w_pend        = '0;
  assign w_load_yaw    = w_wrap;
  assign w_load_pend   = 1'b0;
  assign w_int_set     = w_wrap && r_int1[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_int1     <= '0;
      r_ctrl2    <= '0;
      r_ctrl5    <= '0;
      r_outz     <= '0;
      r_int      <= 1'b0;
      r_smpl     <= 1'b0;
      r_smpl_cnt <= '0;
    end else begin
      if (w_wr_commit) begin
        case (r_cmd[6:0])
          7'h0D:   r_int1  <= r_shft[7:0];
          7'h11:   r_ctrl2 <= r_shft[7:0];
          7'h14:   r_ctrl5 <= r_shft[7:0];
          default: ;
        endcase
      end
      if (!gyro_en || w_wrap) r_smpl_cnt <= '0;
      else                    r_smpl_cnt <= r_smpl_cnt + 1'b1;
      r_smpl <= w_wrap;
      if (w_load_yaw)       r_outz <= yaw_in;
      else if (w_load_pend) r_outz <= w_pend;
      // A sample landing on the 0x27 completion keeps INT set; disabling it in INT1_CTRL always wins.
      if (w_int_clr_wr)     r_int <= 1'b0;
      else if (w_int_set)   r_int <= 1'b1;
      else if (w_rd27_done) r_int <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inert_serf.sv
// Directed bench for inert_serf: register access, sampler timing, INT set/clear, abort and BDU ordering.
module tb_inert_serf;

  localparam int SMPL = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic               SS_n, SCLK, MOSI;
  logic               MISO, INT, smpl, gyro_en;
  logic signed [15:0] yaw_in;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int g_cyc = 0;

  inert_serf #(.SMPL_CYCLES(SMPL), .WHO_AM_I_VAL(8'h6A)) dut (
    .clk     (clk),
    .rst     (rst),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .INT     (INT),
    .yaw_in  (yaw_in),
    .smpl    (smpl),
    .gyro_en (gyro_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monarch drives MOSI on the SCLK fall and samples MISO on the rise; each half lasts 5 clk.
  task automatic spi_bit(input logic b, output logic m);
    SCLK = 1'b0;
    MOSI = b;
    tick(5);
    SCLK = 1'b1;
    m = MISO;
    tick(5);
  endtask

  task automatic spi_frame(input logic [15:0] tx, input int nbits, input int ph, output logic [15:0] rx);
    logic m;
    rx   = '0;
    SS_n = 1'b0;
    tick(4);
    for (int i = 15; i >= 16 - nbits; i--) begin
      spi_bit(tx[i], m);
      rx[i] = m;
    end
    tick(2);
    if (ph >= 0) begin
      for (int g = 0; g < 2 * SMPL && ((cyc - g_cyc) % SMPL) != ph; g++) tick(1);
    end
    SS_n = 1'b1;
  endtask

  task automatic spi_read(input logic [6:0] a, output logic [15:0] rx);
    spi_frame({1'b1, a, 8'h00}, 16, -1, rx);
    tick(6);
  endtask

  task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
    logic [15:0] rx;
    spi_frame({1'b0, a, d}, 16, -1, rx);
    tick(6);
  endtask

  initial begin
    logic [15:0] rx;
    logic        m;
    int          found;
    int          cnt;

    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0; yaw_in = 16'shF123;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_miso", {15'd0, MISO}, 16'd0);
    check("rst_int", {15'd0, INT}, 16'd0);
    check("rst_smpl", {15'd0, smpl}, 16'd0);
    check("rst_gyro_en", {15'd0, gyro_en}, 16'd0);

    spi_read(7'h0F, rx);
    check("who_am_i", {8'h00, rx[7:0]}, 16'h006A);
    check("who_cmd_miso", {8'h00, rx[15:8]}, 16'h0000);
    spi_read(7'h0D, rx);
    check("int1_reset", {8'h00, rx[7:0]}, 16'h0000);
    spi_write(7'h0F, 8'h55);
    spi_read(7'h0F, rx);
    check("who_ro", {8'h00, rx[7:0]}, 16'h006A);
    spi_write(7'h30, 8'h77);
    spi_read(7'h30, rx);
    check("unmapped", {8'h00, rx[7:0]}, 16'h0000);

    // Reset lands in the middle of a CTRL2_G write; the tail of that frame must be ignored.
    SS_n = 1'b0;
    tick(4);
    for (int i = 15; i >= 12; i--) spi_bit(1'(16'h1160 >> i), m);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int i = 11; i >= 0; i--) spi_bit(1'(16'h1160 >> i), m);
    tick(2);
    SS_n = 1'b1;
    tick(6);
    check("midrst_gyro_en", {15'd0, gyro_en}, 16'd0);
    spi_read(7'h11, rx);
    check("midrst_ctrl2", {8'h00, rx[7:0]}, 16'h0000);

    spi_write(7'h0D, 8'h02);
    spi_write(7'h14, 8'h40);
    check("gyro_off_pre", {15'd0, gyro_en}, 16'd0);
    spi_frame(16'h1160, 16, -1, rx);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick(1);
      if (gyro_en) begin found = 1; g_cyc = cyc; end
    end
    check("gyro_en_rise", found[15:0], 16'd1);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      tick(1);
      if (smpl) found = 1;
    end
    check("smpl_seen", found[15:0], 16'd1);
    check("smpl_latency", 16'(cyc - g_cyc), 16'd64);
    check("int_set", {15'd0, INT}, 16'd1);

    spi_read(7'h0D, rx);
    check("rb_int1", {8'h00, rx[7:0]}, 16'h0002);
    spi_read(7'h11, rx);
    check("rb_ctrl2", {8'h00, rx[7:0]}, 16'h0060);
    spi_read(7'h14, rx);
    check("rb_ctrl5", {8'h00, rx[7:0]}, 16'h0040);

    spi_read(7'h26, rx);
    check("outz_l", {8'h00, rx[7:0]}, 16'h0023);
    spi_frame(16'hA700, 16, 20, rx);
    tick(3);
    check("outz_h", {8'h00, rx[7:0]}, 16'h00F1);
`ifdef INERT_SERF_BDU_EN
    check("int_after_27", {15'd0, INT}, 16'd1);
`else
    check("int_after_27", {15'd0, INT}, 16'd0);
`endif
    tick(6);

    spi_frame(16'hA700, 16, 61, rx);
    tick(3);
    check("collide_int", {15'd0, INT}, 16'd1);
    check("collide_smpl", {15'd0, smpl}, 16'd1);
    tick(6);

    spi_frame(16'h0D00, 10, -1, rx);
    tick(6);
    spi_read(7'h0D, rx);
    check("abort_int1", {8'h00, rx[7:0]}, 16'h0002);
    spi_read(7'h0F, rx);
    check("abort_next", {8'h00, rx[7:0]}, 16'h006A);

    spi_read(7'h26, rx);
    check("bdu_l0", {8'h00, rx[7:0]}, 16'h0023);
    yaw_in = 16'sh0456;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      tick(1);
      if (smpl) found = 1;
    end
    check("bdu_wrap", found[15:0], 16'd1);
    tick(2);
    spi_read(7'h27, rx);
`ifdef INERT_SERF_BDU_EN
    check("bdu_h", {8'h00, rx[7:0]}, 16'h00F1);
`else
    check("bdu_h", {8'h00, rx[7:0]}, 16'h0004);
`endif
    spi_read(7'h26, rx);
    check("bdu_l1", {8'h00, rx[7:0]}, 16'h0056);

    check("int_pre_dis", {15'd0, INT}, 16'd1);
    spi_frame(16'h0D00, 16, 30, rx);
    tick(3);
    check("int_dis_clr", {15'd0, INT}, 16'd0);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      tick(1);
      if (smpl) found = 1;
    end
    tick(1);
    check("int_dis_hold", {15'd0, INT}, 16'd0);

    spi_write(7'h11, 8'h00);
    check("gyro_dis", {15'd0, gyro_en}, 16'd0);
    yaw_in = 16'sh7777;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (smpl) cnt++;
    end
    check("no_smpl_off", cnt[15:0], 16'd0);
    spi_read(7'h26, rx);
    check("outz_kept_l", {8'h00, rx[7:0]}, 16'h0056);
    spi_read(7'h27, rx);
    check("outz_kept_h", {8'h00, rx[7:0]}, 16'h0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
